ecc_seq: RTL and testbench
==========================

Name: ecc_seq

Overview:
- Program sequencer for the ECC datapath. Drives `ins_addr` into the instruction ROM and decodes the returned 21-bit word.
- Expands LOOP instructions in hardware and consumes NOP bubbles.
- Issues each remaining operation to the field-arithmetic datapath over a valid/ready handshake.
- Sits between the top-level controller (start/done) and the arithmetic unit.

Parameters:
- `PROG_LEN`, 70: number of valid ROM words, addresses 0..PROG_LEN-1 (1..256).
- `LOOP_DEPTH`, 2: nesting depth of the hardware loop stack (1..4).

Ports:
- `clk`  in  1  clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin program at address 0; ignored unless idle.
- `busy`  out  1  high from the cycle after an accepted start until `done`.
- `done`  out  1  one-cycle pulse at program completion or abort.
- `err`  out  1  sticky loop-stack overflow flag; cleared by `rst` or an accepted start.
- `ins_addr`  out  8  ROM address (= PC).
- `ins_read`  in  21  ROM data, combinational from `ins_addr`.
- `op_valid`  out  1  issued operation valid.
- `op_ready`  in  1  datapath accepts the operation.
- `op_code`  out  3  `ins_read[20:18]` of the issued word.
- `op_sel`  out  2  `ins_read[17:16]`.
- `op_a`  out  8  `ins_read[15:8]`.
- `op_b`  out  8  `ins_read[7:0]`.
- `issue_cnt`  out  16  count of completed handshakes (see Optional Feature).

Behaviour:
- Reset:
  - state = IDLE; PC = 0, so `ins_addr` = 0.
  - `busy`, `done`, `err`, `op_valid` = 0; `op_*` = 0; `issue_cnt` = 0; loop stack empty.
  - Reset mid-run abandons the program immediately. No `done` is produced.
- Instruction fields: op[20:18], sel[17:16], a[15:8], b[7:0]. Opcode 000 = NOP, 010 = LOOP; all others are datapath ops.
- States:
  - IDLE: `start` -> RUN; PC = 0; `err` cleared.
  - RUN: one instruction processed per cycle; transitions below.
  - DRAIN: waits for the outstanding handshake to complete.
  - FIN: drives the `done` pulse, then returns to IDLE.
- Advance condition in RUN: `!op_valid || op_ready`. When false (stall), PC, loop stack and `op_*` all hold.
- On advance, the word at PC is handled as follows:
  - NOP: `op_valid` <= 0 next cycle (bubble); PC advances.
  - LOOP: count N = a; body = PC+1 .. PC+b.
    - b == 0: body extends to PROG_LEN-1.
    - N >= 1: push {start = PC+1, end, remaining = N}; PC = PC+1. Not issued; `op_valid` <= 0.
    - N == 0: skip the body; PC = end+1. Nothing is pushed.
  - Other op: `op_*` <= fields; `op_valid` <= 1; PC advances.
- Instruction latency: the word read at cycle t appears on `op_*` at t+1.
- PC advance: if the top of stack has end == PC:
  - remaining > 1: decrement remaining and set PC = start.
  - otherwise: pop, then re-check the new top in the same cycle (nested loops sharing an end address). PC = PC+1 if no loop matches.
- Completion: when the advance leaves the last address (PC == PROG_LEN-1, no loop-back) -> DRAIN.
  - DRAIN holds until `!op_valid`, or until `op_valid && op_ready`, which clears `op_valid`.
  - Then FIN: `done` = 1 for one cycle, `busy` = 0, IDLE.
- Overflow: LOOP with N >= 1 while the stack is full.
  - `err` = 1; the word is not pushed; no further instructions are fetched.
  - Enter DRAIN and finish normally, with `done` pulsed.
- `start` while busy is ignored. PC is 8 bits and never wraps past PROG_LEN-1.

Optional Feature:
- Macro `ECC_SEQ_ICOUNT_EN`.
- Defined: `issue_cnt` increments on every `op_valid && op_ready` cycle, saturates at 0xFFFF, and clears on accepted start and on `rst`.
- Undefined: `issue_cnt` is tied to 0 and no counter logic is generated.

Test Plan:
- Straight-line: PROG_LEN=4; ROM = NOP, 0x120302 (op100 sel10 a03 b02), NOP, 0x110302; `op_ready`=1; pulse start.
  - `ins_addr` steps 0,1,2,3.
  - `op_valid` is high two cycles: op=100/sel=10/a=03/b=02, then op=100/sel=01.
  - `done` pulses one cycle after the last issue; `issue_cnt` = 2 with the macro, 0 without.
- Backpressure: same program, `op_ready` low for 3 cycles on the first issue.
  - `op_*` and `ins_addr` are held stable for the stall.
  - No instruction is lost or duplicated; `done` arrives 3 cycles later than the unstalled run.
- LOOP: ROM[0] = LOOP a=3 b=2, ROM[1..2] = ops X, Y; PROG_LEN=3.
  - Issue order is X,Y,X,Y,X,Y; then `done`; `issue_cnt` = 6.
- Zero count: LOOP a=0 b=2 followed by X, Y, Z.
  - Only Z is issued; the stack stays empty.
- Overflow: LOOP_DEPTH=1; ROM = LOOP a=2 b=0, LOOP a=2 b=0, X.
  - `err` = 1; X is never issued; `done` pulses once; the next start clears `err`.
- Reset mid-run: assert `rst` during a stalled issue inside a loop.
  - Next cycle: `op_valid` = 0, `busy` = 0, `ins_addr` = 0, no `done`.
  - A subsequent start runs the program from the beginning.

Source files
------------

// File: rtl/ecc_seq.sv
// ECC program sequencer: ROM fetch, hardware LOOP expansion, valid/ready issue.
// Optional issue counter enabled by ECC_SEQ_ICOUNT_EN.
module ecc_seq #(
    parameter int PROG_LEN   = 70,
    parameter int LOOP_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  ins_addr,
    input  logic [20:0] ins_read,
    output logic        op_valid,
    input  logic        op_ready,
    output logic [2:0]  op_code,
    output logic [1:0]  op_sel,
    output logic [7:0]  op_a,
    output logic [7:0]  op_b,
    output logic [15:0] issue_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_FIN
    } state_t;

    localparam logic [7:0] LAST = 8'(PROG_LEN - 1);

    state_t      r_state;
    state_t      w_state_n;
    logic [7:0]  r_pc;
    logic [7:0]  w_pc_n;
    logic [2:0]  r_sp;
    logic [2:0]  w_sp_n;
    logic [7:0]  r_st_start [4];
    logic [7:0]  r_st_end   [4];
    logic [7:0]  r_st_rem   [4];
    logic        r_err;
    logic        r_op_valid;
    logic [2:0]  r_op_code;
    logic [1:0]  r_op_sel;
    logic [7:0]  r_op_a;
    logic [7:0]  r_op_b;

    logic [2:0]  w_op;
    logic [7:0]  w_a;
    logic [7:0]  w_b;
    logic        w_is_nop;
    logic        w_is_loop;
    logic [8:0]  w_sum;
    logic [7:0]  w_end;
    logic        w_skip;
    logic        w_push_req;
    logic        w_full;
    logic [7:0]  w_from;
    logic        w_advance;
    logic [2:0]  w_pop_sp;
    logic        w_lb;
    logic [1:0]  w_lb_idx;
    logic        w_stop;
    logic        w_push;
    logic        w_dec;
    logic        w_issue;
    logic        w_valid_n;
    logic        w_err_set;
    logic        w_clr;

    assign w_op      = ins_read[20:18];
    assign w_a       = ins_read[15:8];
    assign w_b       = ins_read[7:0];
    assign w_is_nop  = (w_op == 3'b000);
    assign w_is_loop = (w_op == 3'b010);
    assign w_sum     = {1'b0, r_pc} + {1'b0, w_b};
    assign w_end     = (w_b == 8'd0 || w_sum > {1'b0, LAST}) ?
                       LAST : w_sum[7:0];
    // A loop with an empty body (count 0 or sitting on the last word) is skipped
    assign w_skip     = w_is_loop && (w_a == 8'd0 || r_pc == LAST);
    assign w_push_req = w_is_loop && !w_skip;
    assign w_full     = (r_sp == 3'(LOOP_DEPTH));
    assign w_from     = w_skip ? w_end : r_pc;
    assign w_advance  = !r_op_valid || op_ready;

    // Walk the stack from the top: exhausted loops ending here pop,
    // the first live one loops back, a non-matching end stops the walk.
    always_comb begin
        w_pop_sp = r_sp;
        w_lb     = 1'b0;
        w_lb_idx = 2'd0;
        w_stop   = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            if (!w_stop && 3'(k) < r_sp) begin
                if (r_st_end[k] == w_from) begin
                    if (r_st_rem[k] > 8'd1) begin
                        w_lb     = 1'b1;
                        w_lb_idx = 2'(k);
                        w_stop   = 1'b1;
                    end else begin
                        w_pop_sp = 3'(k);
                    end
                end else begin
                    w_stop = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_n;
    end

    always_comb begin
        w_state_n = r_state;
        w_pc_n    = r_pc;
        w_sp_n    = r_sp;
        w_push    = 1'b0;
        w_dec     = 1'b0;
        w_issue   = 1'b0;
        w_valid_n = r_op_valid;
        w_err_set = 1'b0;
        w_clr     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_valid_n = 1'b0;
                if (start) begin
                    w_state_n = S_RUN;
                    w_pc_n    = 8'd0;
                    w_sp_n    = 3'd0;
                    w_clr     = 1'b1;
                end
            end
            S_RUN: begin
                if (w_advance) begin
                    w_valid_n = 1'b0;
                    if (w_push_req) begin
                        if (w_full) begin
                            w_err_set = 1'b1;
                            w_state_n = S_DRAIN;
                        end else begin
                            w_push = 1'b1;
                            w_pc_n = r_pc + 8'd1;
                            w_sp_n = r_sp + 3'd1;
                        end
                    end else begin
                        if (!w_is_nop && !w_is_loop) begin
                            w_issue   = 1'b1;
                            w_valid_n = 1'b1;
                        end
                        w_sp_n = w_pop_sp;
                        if (w_lb) begin
                            w_dec  = 1'b1;
                            w_pc_n = r_st_start[w_lb_idx];
                        end else if (w_from == LAST) begin
                            w_state_n = S_DRAIN;
                        end else begin
                            w_pc_n = w_from + 8'd1;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (!r_op_valid || op_ready) begin
                    w_valid_n = 1'b0;
                    w_state_n = S_FIN;
                end
            end
            S_FIN: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= 8'd0;
            r_sp       <= 3'd0;
            r_err      <= 1'b0;
            r_op_valid <= 1'b0;
            r_op_code  <= 3'd0;
            r_op_sel   <= 2'd0;
            r_op_a     <= 8'd0;
            r_op_b     <= 8'd0;
            for (int k = 0; k < 4; k++) begin
                r_st_start[k] <= 8'd0;
                r_st_end[k]   <= 8'd0;
                r_st_rem[k]   <= 8'd0;
            end
        end else begin
            r_pc       <= w_pc_n;
            r_sp       <= w_sp_n;
            r_op_valid <= w_valid_n;
            if (w_push) begin
                r_st_start[r_sp[1:0]] <= r_pc + 8'd1;
                r_st_end[r_sp[1:0]]   <= w_end;
                r_st_rem[r_sp[1:0]]   <= w_a;
            end
            if (w_dec)
                r_st_rem[w_lb_idx] <= r_st_rem[w_lb_idx] - 8'd1;
            if (w_issue) begin
                r_op_code <= w_op;
                r_op_sel  <= ins_read[17:16];
                r_op_a    <= w_a;
                r_op_b    <= w_b;
            end
            if (w_clr)          r_err <= 1'b0;
            else if (w_err_set) r_err <= 1'b1;
        end
    end

`ifdef ECC_SEQ_ICOUNT_EN
    logic [15:0] r_icnt;

    always_ff @(posedge clk) begin
        if (rst || w_clr)
            r_icnt <= 16'd0;
        else if (r_op_valid && op_ready && r_icnt != 16'hFFFF)
            r_icnt <= r_icnt + 16'd1;
    end

    assign issue_cnt = r_icnt;
`else
    assign issue_cnt = 16'd0;
`endif

    assign busy     = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done     = (r_state == S_FIN);
    assign err      = r_err;
    assign ins_addr = r_pc;
    assign op_valid = r_op_valid;
    assign op_code  = r_op_code;
    assign op_sel   = r_op_sel;
    assign op_a     = r_op_a;
    assign op_b     = r_op_b;

endmodule

// File: tb/tb_ecc_seq.sv
// Directed bench for ecc_seq: straight-line, stall, loop, zero-count,
// overflow and mid-run reset programs on a 4-word ROM.
module tb_ecc_seq;

    localparam logic [20:0] OP1 = 21'h120302;
    localparam logic [20:0] OP2 = 21'h110302;
    localparam logic [20:0] LP3 = 21'h080302;
    localparam logic [20:0] LP0 = 21'h080002;
    localparam logic [20:0] LPO = 21'h080200;
    localparam logic [20:0] XOP = 21'h0C1122;
    localparam logic [20:0] YOP = 21'h1C3344;
    localparam logic [20:0] ZOP = 21'h140A0B;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  ins_addr;
    logic [20:0] ins_read;
    logic        op_valid;
    logic        op_ready = 1'b1;
    logic [2:0]  op_code;
    logic [1:0]  op_sel;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic [15:0] issue_cnt;

    logic [20:0] rom [4];
    logic [20:0] iss [$];
    logic [20:0] exp_q [$];
    logic [7:0]  trace [$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          last_iss_cyc = 0;
    int          stall_left = 0;
    int          lat0;
    int          lat1;
    int          lat;
    logic        prev_stall = 1'b0;
    logic [31:0] snap = 32'd0;

    always #5 clk = ~clk;

    assign ins_read = (ins_addr < 8'd4) ? rom[ins_addr[1:0]] : 21'h0;

    ecc_seq #(.PROG_LEN(4), .LOOP_DEPTH(2)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .ins_addr  (ins_addr),
        .ins_read  (ins_read),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_code   (op_code),
        .op_sel    (op_sel),
        .op_a      (op_a),
        .op_b      (op_b),
        .issue_cnt (issue_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, want);
    endtask

    function automatic logic [31:0] icnt(input int n);
`ifdef ECC_SEQ_ICOUNT_EN
        return 32'(n);
`else
        return 32'(n * 0);
`endif
    endfunction

    function automatic logic [31:0] obs();
        return {3'd0, ins_addr, op_code, op_sel, op_a, op_b};
    endfunction

    // Ready driver and observer share one process to keep ordering fixed
    initial forever begin
        @(negedge clk);
        if (prev_stall) chk("hold", obs(), snap);
        if (stall_left > 0 && op_valid) begin
            op_ready = 1'b0;
            stall_left--;
        end else begin
            op_ready = 1'b1;
        end
        prev_stall = op_valid && !op_ready && !rst;
        snap = obs();
        if (op_valid && op_ready && !rst) begin
            iss.push_back({op_code, op_sel, op_a, op_b});
            last_iss_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy && (trace.size() == 0 || trace[$] != ins_addr))
            trace.push_back(ins_addr);
        cyc++;
    end

    task automatic run_prog(output int l);
        int n;
        int st;
        iss.delete();
        trace.delete();
        done_cnt = 0;
        done_cyc = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        st = cyc;
        chk("busy_go", 32'(busy), 32'd1);
        chk("err_clr", 32'(err), 32'd0);
        n = 0;
        while (done_cnt == 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        chk("done_once", 32'(done_cnt), 32'd1);
        chk("busy_end", 32'(busy), 32'd0);
        l = done_cyc - st;
    endtask

    task automatic chk_iss(input string tag);
        chk({tag, "_n"}, 32'(iss.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s%0d", tag, i),
                32'((i < iss.size()) ? iss[i] : 21'h1FFFFF),
                32'(exp_q[i]));
    endtask

    task automatic chk_trace(input string tag);
        chk({tag, "_n"}, 32'(trace.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s%0d", tag, i),
                32'((i < trace.size()) ? trace[i] : 8'hFF), 32'(i));
    endtask

    task automatic exp_loop();
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(XOP);
            exp_q.push_back(YOP);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst   = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) rom[i] = 21'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_valid", 32'(op_valid), 32'd0);
        chk("rst_addr_ops", obs(), 32'd0);
        chk("rst_icnt", 32'(issue_cnt), 32'd0);
        rst = 1'b0;

        rom[0] = 21'h0; rom[1] = OP1; rom[2] = 21'h0; rom[3] = OP2;
        run_prog(lat0);
        exp_q.delete();
        exp_q.push_back(OP1);
        exp_q.push_back(OP2);
        chk_iss("sl");
        chk_trace("sl_addr");
        chk("sl_done_gap", 32'(done_cyc - last_iss_cyc), 32'd1);
        chk("sl_icnt", 32'(issue_cnt), icnt(2));
        chk("sl_err", 32'(err), 32'd0);

        stall_left = 3;
        run_prog(lat1);
        chk_iss("bp");
        chk_trace("bp_addr");
        chk("bp_delay", 32'(lat1 - lat0), 32'd3);
        chk("bp_icnt", 32'(issue_cnt), icnt(2));

        rom[0] = LP3; rom[1] = XOP; rom[2] = YOP; rom[3] = 21'h0;
        run_prog(lat);
        exp_loop();
        chk_iss("lp");
        chk("lp_icnt", 32'(issue_cnt), icnt(6));

        rom[0] = LP0; rom[3] = ZOP;
        run_prog(lat);
        exp_q.delete();
        exp_q.push_back(ZOP);
        chk_iss("zc");
        chk("zc_icnt", 32'(issue_cnt), icnt(1));

        rom[0] = LPO; rom[1] = LPO; rom[2] = LPO; rom[3] = XOP;
        run_prog(lat);
        exp_q.delete();
        chk_iss("ov");
        chk("ov_err", 32'(err), 32'd1);

        rom[0] = LP3; rom[1] = XOP; rom[2] = YOP; rom[3] = 21'h0;
        run_prog(lat);
        chk("ov_err_after", 32'(err), 32'd0);

        stall_left = 1000;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 0;
        while (!op_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        chk("mr_pre_valid", 32'(op_valid), 32'd1);
        chk("mr_pre_ready", 32'(op_ready), 32'd0);
        rst = 1'b1;
        done_cnt = 0;
        @(posedge clk); #1;
        chk("mr_valid", 32'(op_valid), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_addr", 32'(ins_addr), 32'd0);
        chk("mr_done", 32'(done), 32'd0);
        rst = 1'b0;
        stall_left = 0;
        repeat (5) @(posedge clk);
        #1;
        chk("mr_nodone", 32'(done_cnt), 32'd0);
        run_prog(lat);
        exp_loop();
        chk_iss("mr");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
